// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants for the truth-table sweeper: FSM encoding and MISR parameters.
// The optional signature engine is enabled with TRUTH_TABLE_SWEEPER_MISR_EN.
package truth_table_sweeper_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SIG_W = 16;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [ST_W-1:0] ST_SAMPLE = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

  // One serial MISR step: shift left, fold in polynomial on carry-out, xor data into bit 0.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic             din);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? MISR_POLY : '0;
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, din};
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// Serial 16-bit signature register compressing the sampled response stream.
// Instantiated by truth_table_sweeper only when TRUTH_TABLE_SWEEPER_MISR_EN is defined.
module sweep_misr
  import truth_table_sweeper_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= MISR_SEED;
    end else if (shift_en) begin
      r_sig <= misr_step(r_sig, din);
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response engine for an N-input combinational circuit.
// Define TRUTH_TABLE_SWEEPER_MISR_EN to add the 16-bit response signature output.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N      = 7,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_y,
  output logic [N-1:0]     vec_out,
  output logic             busy,
  output logic             done,
  output logic [N:0]       ones_count,
  output logic             found,
  output logic [N-1:0]     first_one
`ifdef TRUTH_TABLE_SWEEPER_MISR_EN
  ,
  output logic [SIG_W-1:0] signature
`endif
);

  localparam int unsigned      ONES_W      = N + 1;
  localparam logic [N-1:0]     VEC_LAST    = '1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;
  // With no settle time every vector goes straight to its sample cycle.
  localparam logic [ST_W-1:0]  ST_NEXT_VEC = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  logic [ST_W-1:0]   r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [N-1:0]      r_vec,   w_vec_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;
  logic [ONES_W-1:0] r_ones,  w_ones_nxt;
  logic              r_found, w_found_nxt;
  logic [N-1:0]      r_first, w_first_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ones  <= '0;
      r_found <= 1'b0;
      r_first <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ones  <= w_ones_nxt;
      r_found <= w_found_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Next-state and result update; start is only honoured from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_ones_nxt  = r_ones;
    w_found_nxt = r_found;
    w_first_nxt = r_first;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_vec_nxt   = '0;
          w_ones_nxt  = '0;
          w_found_nxt = 1'b0;
          w_first_nxt = '0;
          w_done_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_NEXT_VEC;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (dut_y) begin
          w_ones_nxt = r_ones + ONES_W'(1);
          if (!r_found) begin
            w_found_nxt = 1'b1;
            w_first_nxt = r_vec;
          end
        end
        if (r_vec == VEC_LAST) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_nxt   = r_vec + N'(1);
          w_state_nxt = ST_NEXT_VEC;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign vec_out    = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ones_count = r_ones;
  assign found      = r_found;
  assign first_one  = r_first;

`ifdef TRUTH_TABLE_SWEEPER_MISR_EN
  logic w_misr_clear;
  logic w_misr_shift;

  // Seed on an accepted start, compress one response bit per sample cycle.
  assign w_misr_clear = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_misr_shift = (r_state == ST_SAMPLE);

  sweep_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_misr_clear),
    .shift_en (w_misr_shift),
    .din      (dut_y),
    .sig      (signature)
  );
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: three sweeper instances (N/SETTLE = 7/2, 3/0, 4/1) driven by
// random truth tables, with expected results derived directly from each table.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int n_blocks_done = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int n_of(input int g);
    case (g)
      0:       return 7;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int s_of(input int g);
    case (g)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NN    = n_of(g);
    localparam int SS    = s_of(g);
    localparam int NV    = 1 << NN;
    localparam int SWEEP = NV * (SS + 1);

    typedef struct {
      int          accept_cyc;
      int          done_cyc;
      int          ones;
      int          found;
      int          first;
      logic [15:0] sig;
    } exp_t;

    logic          rst;
    logic          start;
    logic          dut_y;
    logic [NN-1:0] vec_out;
    logic          busy;
    logic          done;
    logic [NN:0]   ones_count;
    logic          found;
    logic [NN-1:0] first_one;
`ifdef TRUTH_TABLE_SWEEPER_MISR_EN
    logic [15:0]   signature;
`endif

    bit   tt [NV];
    exp_t q[$];
    logic prev_done = 1'b0;

    assign dut_y = tt[vec_out];

    truth_table_sweeper #(.N(NN), .SETTLE(SS)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dut_y      (dut_y),
      .vec_out    (vec_out),
      .busy       (busy),
      .done       (done),
      .ones_count (ones_count),
      .found      (found),
      .first_one  (first_one)
`ifdef TRUTH_TABLE_SWEEPER_MISR_EN
      ,
      .signature  (signature)
`endif
    );

    // Reference: count, lowest set index and CRC-style signature of the table.
    function automatic exp_t model(input int accept_cyc);
      exp_t e;
      e.accept_cyc = accept_cyc;
      e.done_cyc   = accept_cyc + SWEEP;
      e.ones       = 0;
      e.found      = 0;
      e.first      = 0;
      e.sig        = 16'hFFFF;
      for (int v = 0; v < NV; v++) begin
        if (tt[v]) begin
          if (e.found == 0) e.first = v;
          e.found = 1;
          e.ones++;
        end
        e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, tt[v]};
      end
      return e;
    endfunction

    task automatic check_reset_values(input string tag);
      check({tag, "_vec"},   longint'(vec_out),    0);
      check({tag, "_busy"},  longint'(busy),       0);
      check({tag, "_done"},  longint'(done),       0);
      check({tag, "_ones"},  longint'(ones_count), 0);
      check({tag, "_found"}, longint'(found),      0);
      check({tag, "_first"}, longint'(first_one),  0);
`ifdef TRUTH_TABLE_SWEEPER_MISR_EN
      check({tag, "_sig"},   longint'(signature),  0);
`endif
    endtask

    task automatic issue_start();
      exp_t e;
      e = model(cyc + 1);
      start = 1'b1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
    endtask

    task automatic wait_drain();
      for (int k = 0; k < SWEEP + 20 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) begin
        check("sweep_timeout", longint'(q.size()), 0);
        q.delete();
      end
    endtask

    // Monitor: in-flight sweep must show busy=1/done=0; on done rising, score results.
    always @(negedge clk) begin
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", longint'(cyc),        longint'(e.done_cyc));
          check("ones_count", longint'(ones_count), longint'(e.ones));
          check("found",      longint'(found),      longint'(e.found));
          check("first_one",  longint'(first_one),  longint'(e.first));
          check("vec_last",   longint'(vec_out),    longint'(NV - 1));
          check("busy_end",   longint'(busy),       0);
`ifdef TRUTH_TABLE_SWEEPER_MISR_EN
          check("signature",  longint'(signature),  longint'(e.sig));
`endif
        end
      end else if (q.size() != 0 && cyc >= q[0].accept_cyc) begin
        check("busy_in_sweep", longint'({busy, done}), 2);
      end
      prev_done = done;
    end

    initial begin
      int hold;
      rst   = 1'b1;
      start = 1'b0;
      foreach (tt[i]) tt[i] = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      for (int r = 0; r < 7; r++) begin
        foreach (tt[i]) begin
          case (r)
            0:       tt[i] = 1'b0;
            1:       tt[i] = 1'b1;
            2:       tt[i] = (i == NV - 1);
            3:       tt[i] = bit'(i & 1);
            4:       tt[i] = 1'b0;
            5:       tt[i] = bit'($urandom_range(0, 1));
            default: tt[i] = ($urandom_range(0, 7) == 0) && (i >= NV / 2);
          endcase
        end
        issue_start();
        if (r == 2 || r == 5) begin
          // Extra start pulse mid-sweep must be ignored.
          hold = (SWEEP > 100) ? 49 : SWEEP / 2 - 1;
          repeat (hold) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        wait_drain();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset mid-sweep discards everything; a later sweep completes normally.
      foreach (tt[i]) tt[i] = bit'($urandom_range(0, 1));
      issue_start();
      hold = (SWEEP > 80) ? 39 : SWEEP / 2 - 1;
      repeat (hold) @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      check_reset_values("midrst");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst", longint'({busy, done}), 0);
      issue_start();
      wait_drain();

      n_blocks_done++;
    end
  end

  initial begin
    for (int k = 0; k < 60000 && n_blocks_done < 3; k++) @(negedge clk);
    if (n_blocks_done < 3) check("global_timeout", longint'(n_blocks_done), 3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
